part_o_split: RTL
=================

// Module: part_o_split
// PURPOSE
//  Inverse of the 3:1 merge stage: takes one byte stream (wen/i_data) and distributes it
//  round-robin over three output channels (valid/o_data/ren), one per downstream partition.
//  Each channel is buffered in a small show-ahead FIFO.
//  freeze asserts when no channel can accept a byte; it is the backpressure used by the
//  partition interface to freeze the upstream clock.
// PARAMETERS
//  DEPTH   4   entries per channel FIFO; power of two, >=2
//  DW      8   data width of i_data / o_data_k
// PORTS
//  clk_i     in   1      single clock; all logic rising-edge
//  reset     in   1      asynchronous, active-high; clears all state
//  wen       in   1      write strobe; i_data is accepted when wen & !freeze
//  i_data    in   DW     input byte
//  freeze    out  1      all three channel FIFOs full; writes ignored
//  ren       in   3      per-channel read strobe; pops when ren[k] & valid[k]
//  valid     out  3      valid[k] = channel k FIFO not empty
//  o_data0   out  DW     head of channel 0 (show-ahead)
//  o_data1   out  DW     head of channel 1
//  o_data2   out  DW     head of channel 2
//  drop_cnt  out  16     dropped-write counter (only with PART_SPLIT_DROPCNT_EN)
// BEHAVIOUR
//  Reset values: valid=3'b000, freeze=0, o_dataK=0, rr_ptr=0, drop_cnt=0.
//  Reset mid-operation discards all buffered bytes immediately (async).
//  Selection: rr_ptr in {0,1,2}. On an accepted write, target = first non-full channel
//   scanning rr_ptr, rr_ptr+1, rr_ptr+2 (mod 3). Byte is written that edge.
//   rr_ptr <= target+1 mod 3.
//  Full/empty use registered counts from before the edge. A channel that is full and is
//   being popped in the same cycle is still treated as full for selection.
//  freeze = full0 & full1 & full2, a combinational decode of the registered counts.
//   It rises the cycle after the last slot fills and falls the cycle after any pop.
//  wen while freeze: byte dropped; rr_ptr unchanged; no channel state changes.
//  Latency: a byte written at edge N shows on o_dataK with valid[k]=1 after edge N
//   (visible in cycle N+1).
//  Pop: ren[k] & valid[k] advances the read pointer. ren[k] while !valid[k] is ignored,
//   with no underflow.
//  Simultaneous push and pop on one non-full, non-empty channel: count is unchanged and
//   data ordering is preserved.
//  Pointers are log2(DEPTH) bits and wrap naturally. Count is log2(DEPTH)+1 bits,
//   range 0..DEPTH.
//  o_dataK is driven from FIFO head storage; its value when valid[k]=0 is don't-care
//   after the first write.
// CONFIGURATION
//  PART_SPLIT_DROPCNT_EN defined:
//   - drop_cnt increments on every wen & freeze cycle and saturates at 16'hFFFF.
//   - Reset clears it.
//  Undefined:
//   - drop_cnt is tied to 0 and no counter flops are built.
//   - Port remains present, so the port list is fixed.
// STRUCTURE
//  part_pkg (shared with the merge stage):
//   - NUM_CH=3, DW=8
//   - typedef logic [DW-1:0] data_t
//   - typedef logic [1:0] ch_t
//  Sub-module part_o_fifo(DEPTH,DW), instantiated three times:
//   - push, pop, din, dout, empty, full, registered count
//  Top holds rr_ptr, the selection/priority scan, freeze decode and the optional counter.
// TESTING
//  1. Reset, then wen with bytes 0x11,0x22,0x33,0x44 on consecutive cycles, ren=0
//     -> ch0 holds 0x11,0x44; ch1 holds 0x22; ch2 holds 0x33; valid=3'b111.
//  2. 12 writes with ren=0 (DEPTH=4) -> freeze=1 the cycle after the 12th write.
//     13th write (0xAA) is dropped; drop_cnt=1 when the macro is defined.
//  3. Frozen, then ren[1] pulse for one cycle -> freeze=0 next cycle; the next write
//     lands in ch1 regardless of rr_ptr.
//  4. ch0 at count 2, push to ch0 and ren[0] in the same cycle -> count stays 2 and the
//     pop order matches write order.
//  5. reset asserted for 1 cycle with all FIFOs half full and asynchronous to clk_i
//     -> valid=0 and freeze=0 immediately; the next write goes to ch0.
//  6. ren=3'b111 with all empty for 10 cycles -> valid stays 0; no pointer movement
//     (count=0 checked).

Source files
------------

// File: rtl/part_pkg.sv
// Shared definitions for the partition merge/split stages.
package part_pkg;

  localparam int NUM_CH = 3;
  localparam int DW     = 8;

  typedef logic [DW-1:0] data_t;
  typedef logic [1:0]    ch_t;

  // Channel indices live in 0..2, so the successor wraps explicitly instead of mod 4.
  function automatic ch_t ch_inc(input ch_t c);
    return (c == 2'd2) ? 2'd0 : c + 2'd1;
  endfunction

endpackage

// File: rtl/part_o_split_if.sv
// Byte-stream split bus: one write port in, three show-ahead read channels out.
interface part_o_split_if #(
  parameter int DW = 8
);

  logic          wen;
  logic [DW-1:0] i_data;
  logic          freeze;
  logic [2:0]    ren;
  logic [2:0]    valid;
  logic [DW-1:0] o_data0;
  logic [DW-1:0] o_data1;
  logic [DW-1:0] o_data2;
  logic [15:0]   drop_cnt;

  // The producer/consumer side drives the write and read strobes.
  modport master (
    output wen, i_data, ren,
    input  freeze, valid, o_data0, o_data1, o_data2, drop_cnt
  );

  modport slave (
    input  wen, i_data, ren,
    output freeze, valid, o_data0, o_data1, o_data2, drop_cnt
  );

endinterface

// File: rtl/part_o_fifo.sv
// Small show-ahead FIFO for one split channel; dout always shows the head entry.
module part_o_fifo #(
  parameter int DEPTH = 4,
  parameter int DW    = 8
) (
  input  logic                     clk_i,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic [DW-1:0]            din,
  output logic [DW-1:0]            dout,
  output logic                     empty,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

  logic [DW-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   cnt;
  logic          do_push;
  logic          do_pop;

  // A pop on an empty FIFO is ignored so the pointers can never underflow.
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;

  always_ff @(posedge clk_i or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({do_push, do_pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

  assign dout  = mem[rd_ptr];
  assign empty = (cnt == '0);
  assign full  = (cnt == FULL_CNT);
  assign count = cnt;

endmodule

// File: rtl/part_o_split.sv
// Round-robin 1:3 byte splitter feeding three show-ahead channel FIFOs.
// Optional dropped-write counter enabled by defining PART_SPLIT_DROPCNT_EN.
module part_o_split #(
  parameter int DEPTH = 4,
  parameter int DW    = part_pkg::DW
) (
  input  logic           clk_i,
  input  logic           reset,
  part_o_split_if.slave  bus
);

  import part_pkg::*;

  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  ch_t           rr_ptr;
  ch_t           scan1;
  ch_t           scan2;
  ch_t           target;
  logic [2:0]    full;
  logic [2:0]    empty;
  logic [2:0]    push;
  logic [DW-1:0] dout  [NUM_CH];
  logic [CW-1:0] count [NUM_CH];
  logic          freeze;
  logic          accept;

  // Selection only looks at pre-edge fullness, so a full channel popped this cycle is skipped.
  always_comb begin
    scan1  = ch_inc(rr_ptr);
    scan2  = ch_inc(scan1);
    target = scan2;
    if (!full[rr_ptr]) begin
      target = rr_ptr;
    end else if (!full[scan1]) begin
      target = scan1;
    end
  end

  assign freeze = (count[0] == FULL_CNT) & (count[1] == FULL_CNT) & (count[2] == FULL_CNT);
  assign accept = bus.wen & ~freeze;

  always_comb begin
    push = 3'b000;
    if (accept) begin
      push[target] = 1'b1;
    end
  end

  always_ff @(posedge clk_i or posedge reset) begin
    if (reset) begin
      rr_ptr <= 2'd0;
    end else if (accept) begin
      rr_ptr <= ch_inc(target);
    end
  end

  for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
    part_o_fifo #(
      .DEPTH (DEPTH),
      .DW    (DW)
    ) u_fifo (
      .clk_i (clk_i),
      .reset (reset),
      .push  (push[k]),
      .pop   (bus.ren[k]),
      .din   (bus.i_data),
      .dout  (dout[k]),
      .empty (empty[k]),
      .full  (full[k]),
      .count (count[k])
    );
  end

  assign bus.valid   = ~empty;
  assign bus.freeze  = freeze;
  assign bus.o_data0 = dout[0];
  assign bus.o_data1 = dout[1];
  assign bus.o_data2 = dout[2];

`ifdef PART_SPLIT_DROPCNT_EN
  logic [15:0] drop_cnt;

  // Counts every write attempt that hit a frozen splitter, sticking at all-ones.
  always_ff @(posedge clk_i or posedge reset) begin
    if (reset) begin
      drop_cnt <= 16'h0000;
    end else if (bus.wen && freeze && (drop_cnt != 16'hFFFF)) begin
      drop_cnt <= drop_cnt + 16'h0001;
    end
  end

  assign bus.drop_cnt = drop_cnt;
`else
  assign bus.drop_cnt = 16'h0000;
`endif

endmodule
